reg_file: RTL and testbench

Parametrised multi-port register file for the Citrus CPU. It generalises the single 8-bit write-enabled register to DEPTH words of WIDTH bits, with byte-lane write enables and two independently enabled, registered read ports. Same-cycle writes bypass to the read ports, and register 0 can be configured as hard-wired zero. It sits between decode (read addresses) and write-back (write port) and also serves as the general scratch bank for peripherals.

---
 rtl/reg_file_pkg.sv | 31 +++
 rtl/reg_file_word.sv | 26 ++
 rtl/reg_file.sv | 81 ++++++++
 tb/tb_reg_file.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the register file, decode and write-back.
package reg_file_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 8;

  // Widest word the merge helper handles; callers size-cast in and out.
  localparam int MAX_WIDTH = 256;
  localparam int MAX_BE    = MAX_WIDTH / 8;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic logic [MAX_WIDTH-1:0] merge(input logic [MAX_WIDTH-1:0] old_w,
                                                 input logic [MAX_WIDTH-1:0] new_w,
                                                 input logic [MAX_BE-1:0]    be);
    logic [MAX_WIDTH-1:0] r;
    r = old_w;
    for (int k = 0; k < MAX_BE; k++) begin
      if (be[k]) r[8*k +: 8] = new_w[8*k +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/reg_file_word.sv
// One register word with per-byte-lane write enables and a sticky dirty flag.
// Write latency 1 edge; no backpressure.
module reg_word #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH/8-1:0] lane_we,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   q,
  output logic               dirty
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q     <= '0;
      dirty <= 1'b0;
    end else begin
      for (int k = 0; k < WIDTH/8; k++) begin
        if (lane_we[k]) q[8*k +: 8] <= wdata[8*k +: 8];
      end
      if (|lane_we) dirty <= 1'b1;
    end
  end

endmodule

// File: rtl/reg_file.sv
// Byte-lane-writable register file with two registered, write-first read ports.
// Read and write latency 1 edge; no backpressure, all outputs are flops.
module reg_file
  import reg_file_pkg::*;
#(
  parameter  int WIDTH    = DEF_WIDTH,
  parameter  int DEPTH    = DEF_DEPTH,
  parameter  int ZERO_REG = 1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_we,
  input  logic [ADDR_W-1:0]  i_waddr,
  input  logic [WIDTH-1:0]   i_wdata,
  input  logic [WIDTH/8-1:0] i_wbe,
  input  logic               i_re_a,
  input  logic               i_re_b,
  input  logic [ADDR_W-1:0]  i_raddr_a,
  input  logic [ADDR_W-1:0]  i_raddr_b,
  output logic [WIDTH-1:0]   o_rdata_a,
  output logic [WIDTH-1:0]   o_rdata_b,
  output logic [DEPTH-1:0]   o_dirty
);

  localparam int NB = WIDTH / 8;

  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;
  logic [WIDTH-1:0] wr_old;
  logic [WIDTH-1:0] wr_new;
  logic [WIDTH-1:0] cur_a;
  logic [WIDTH-1:0] cur_b;

  assign wr_ok = i_we && (|i_wbe) && (int'(i_waddr) < DEPTH)
                 && !((ZERO_REG != 0) && (i_waddr == '0));

  for (genvar n = 0; n < DEPTH; n++) begin : g_word
    if ((ZERO_REG != 0) && (n == 0)) begin : g_zero
      assign regs[n]    = '0;
      assign o_dirty[n] = 1'b0;
    end else begin : g_reg
      logic [NB-1:0] lane_we;
      assign lane_we = (wr_ok && (i_waddr == ADDR_W'(n))) ? i_wbe : '0;
      reg_word #(.WIDTH(WIDTH)) u_word (
        .clk     (i_clk),
        .rst     (i_reset),
        .lane_we (lane_we),
        .wdata   (i_wdata),
        .q       (regs[n]),
        .dirty   (o_dirty[n])
      );
    end
  end

  // Unmatched addresses (out of range) fall through to zero; the zero slot reads 0 itself.
  always_comb begin
    wr_old = '0;
    cur_a  = '0;
    cur_b  = '0;
    for (int n = 0; n < DEPTH; n++) begin
      if (i_waddr   == ADDR_W'(n)) wr_old = regs[n];
      if (i_raddr_a == ADDR_W'(n)) cur_a  = regs[n];
      if (i_raddr_b == ADDR_W'(n)) cur_b  = regs[n];
    end
    wr_new = WIDTH'(merge(MAX_WIDTH'(wr_old), MAX_WIDTH'(i_wdata), MAX_BE'(i_wbe)));
    if (wr_ok && (i_raddr_a == i_waddr)) cur_a = wr_new;
    if (wr_ok && (i_raddr_b == i_waddr)) cur_b = wr_new;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rdata_a <= '0;
      o_rdata_b <= '0;
    end else begin
      if (i_re_a) o_rdata_a <= cur_a;
      if (i_re_b) o_rdata_b <= cur_b;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Three register-file variants driven by one stimulus stream, checked against an array model.
module tb_reg_file;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        we = 1'b0, re_a = 1'b0, re_b = 1'b0;
  logic [2:0]  waddr = '0, raddr_a = '0, raddr_b = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wbe = '0;

  logic [31:0] ra0, rb0, ra1, rb1, ra2, rb2;
  logic [7:0]  d0, d1;
  logic [5:0]  d2;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // u0: defaults (8 words, zero reg); u1: no zero reg; u2: 6 words with zero reg
  reg_file u0 (.i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr), .i_wdata(wdata),
               .i_wbe(wbe), .i_re_a(re_a), .i_re_b(re_b), .i_raddr_a(raddr_a),
               .i_raddr_b(raddr_b), .o_rdata_a(ra0), .o_rdata_b(rb0), .o_dirty(d0));
  reg_file #(.ZERO_REG(0)) u1 (.i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr),
               .i_wdata(wdata), .i_wbe(wbe), .i_re_a(re_a), .i_re_b(re_b),
               .i_raddr_a(raddr_a), .i_raddr_b(raddr_b), .o_rdata_a(ra1),
               .o_rdata_b(rb1), .o_dirty(d1));
  reg_file #(.DEPTH(6)) u2 (.i_clk(clk), .i_reset(rst), .i_we(we), .i_waddr(waddr),
               .i_wdata(wdata), .i_wbe(wbe), .i_re_a(re_a), .i_re_b(re_b),
               .i_raddr_a(raddr_a), .i_raddr_b(raddr_b), .o_rdata_a(ra2),
               .o_rdata_b(rb2), .o_dirty(d2));

  logic [31:0] mreg [3][8];
  logic [7:0]  mdirty [3];
  logic [31:0] mra [3];
  logic [31:0] mrb [3];

  function automatic int dep_of(input int i);
    return (i == 2) ? 6 : 8;
  endfunction

  function automatic bit zr_of(input int i);
    return (i != 1);
  endfunction

  function automatic logic [31:0] model_rd(input int i, input logic [2:0] a);
    if (int'(a) >= dep_of(i) || (zr_of(i) && a == 3'd0)) return 32'd0;
    return mreg[i][a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      for (int n = 0; n < 8; n++) mreg[i][n] = '0;
      mdirty[i] = '0;
      mra[i] = '0;
      mrb[i] = '0;
    end
  endtask

  // Write-first: apply the write, then evaluate reads against the updated array.
  task automatic model_edge();
    if (rst) return;
    for (int i = 0; i < 3; i++) begin
      if (we && wbe != 4'd0 && int'(waddr) < dep_of(i) && !(zr_of(i) && waddr == 3'd0)) begin
        for (int k = 0; k < 4; k++)
          if (wbe[k]) mreg[i][waddr][8*k +: 8] = wdata[8*k +: 8];
        mdirty[i][waddr] = 1'b1;
      end
      if (re_a) mra[i] = model_rd(i, raddr_a);
      if (re_b) mrb[i] = model_rd(i, raddr_b);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_ra0", ra0, mra[0]);
      chk("model_rb0", rb0, mrb[0]);
      chk("model_ra1", ra1, mra[1]);
      chk("model_rb1", rb1, mrb[1]);
      chk("model_ra2", ra2, mra[2]);
      chk("model_rb2", rb2, mrb[2]);
      chk("model_dirty0", {24'd0, d0}, {24'd0, mdirty[0]});
      chk("model_dirty1", {24'd0, d1}, {24'd0, mdirty[1]});
      chk("model_dirty2", {26'd0, d2}, {26'd0, mdirty[2][5:0]});
    end
  end

  initial begin
    model_clear();
    #2;
    rst = 1'b1;
    #1;
    chk_en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_dirty", {24'd0, d0}, 32'd0);
    chk("reset_rdata_a", ra0, 32'd0);

    // byte lanes
    we = 1'b1; waddr = 3'd3; wdata = 32'hAABBCCDD; wbe = 4'b1111;
    tick();
    wdata = 32'h11223344; wbe = 4'b0101;
    tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 3'd3;
    tick();
    chk("lanes_rdata", ra0, 32'hAA22CC44);
    chk("lanes_dirty", {24'd0, d0}, 32'h08);
    re_a = 1'b0;

    // bypass
    we = 1'b1; waddr = 3'd2; wdata = 32'h12345678; wbe = 4'b1111;
    tick();
    waddr = 3'd5; wdata = 32'hDEADBEEF;
    re_a = 1'b1; raddr_a = 3'd5; re_b = 1'b1; raddr_b = 3'd2;
    tick();
    chk("bypass_a", ra0, 32'hDEADBEEF);
    chk("bypass_b", rb0, 32'h12345678);
    we = 1'b0; re_a = 1'b0; re_b = 1'b0;

    // zero register
    we = 1'b1; waddr = 3'd0; wdata = 32'hFFFFFFFF; wbe = 4'b1111;
    tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 3'd0;
    tick();
    chk("zero_rd_z1", ra0, 32'd0);
    chk("zero_dirty_z1", {31'd0, d0[0]}, 32'd0);
    chk("zero_rd_z0", ra1, 32'hFFFFFFFF);
    chk("zero_dirty_z0", {31'd0, d1[0]}, 32'd1);
    re_a = 1'b0;

    // hold and out-of-range on the 6-deep instance
    we = 1'b1; waddr = 3'd1; wdata = 32'h55; wbe = 4'b1111;
    tick();
    we = 1'b0; re_a = 1'b1; raddr_a = 3'd1;
    tick();
    chk("hold_read", ra2, 32'h55);
    re_a = 1'b0; raddr_a = 3'd4;
    tick();
    chk("hold_keep", ra2, 32'h55);
    re_a = 1'b1; raddr_a = 3'd7;
    tick();
    chk("oor_read", ra2, 32'd0);
    re_a = 1'b0;
    we = 1'b1; waddr = 3'd7; wdata = 32'hCAFE0000; wbe = 4'b1111;
    tick();
    chk("oor_write_dirty", {26'd0, d2}, 32'h2E);

    // be = 0 is a no-op
    we = 1'b1; waddr = 3'd4; wdata = 32'hFFFFFFFF; wbe = 4'b0000;
    re_b = 1'b1; raddr_b = 3'd4;
    tick();
    we = 1'b0;
    tick();
    chk("be0_read", rb0, 32'd0);
    chk("be0_dirty", {31'd0, d0[4]}, 32'd0);
    re_b = 1'b0;

    // randomized traffic
    repeat (400) begin
      we      = 1'($urandom_range(0, 1));
      waddr   = 3'($urandom_range(0, 7));
      wdata   = $urandom;
      wbe     = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom);
      re_a    = 1'($urandom_range(0, 1));
      re_b    = 1'($urandom_range(0, 1));
      raddr_a = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      raddr_b = ($urandom_range(0, 3) == 0) ? waddr : 3'($urandom_range(0, 7));
      tick();
    end

    // asynchronous reset mid-write
    we = 1'b1; waddr = 3'd6; wdata = 32'h0BADF00D; wbe = 4'b1111;
    re_a = 1'b1; re_b = 1'b1;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    chk("arst_ra0", ra0, 32'd0);
    chk("arst_rb0", rb0, 32'd0);
    chk("arst_ra1", ra1, 32'd0);
    chk("arst_rb2", rb2, 32'd0);
    chk("arst_dirty0", {24'd0, d0}, 32'd0);
    chk("arst_dirty1", {24'd0, d1}, 32'd0);
    chk("arst_dirty2", {26'd0, d2}, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    we = 1'b0;
    for (int a = 0; a < 8; a++) begin
      raddr_a = 3'(a);
      raddr_b = 3'(7 - a);
      tick();
      chk("post_rst_a1", ra1, 32'd0);
      chk("post_rst_b1", rb1, 32'd0);
    end
    re_a = 1'b0; re_b = 1'b0;
    tick();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
